// File: rtl/conv1_pkg.sv
// rtl/conv1_pkg.sv - conv1 layer constants, FSM state type and address helpers.
package conv1_pkg;
  localparam int IN_H   = 227;
  localparam int IN_W   = 227;
  localparam int CH     = 3;
  localparam int K      = 11;
  localparam int STRIDE = 4;
  localparam int OUT_H  = 55;
  localparam int OUT_W  = 55;
  localparam int DW     = 16;
  localparam int TERMS  = CH * K * K;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_FLUSH, S_OUT, S_DONE} conv1_seq_state_t;

  function automatic logic [7:0] in_addr(input logic [5:0] o, input logic [3:0] k);
    return 8'(int'(o) * STRIDE + int'(k));
  endfunction

  // Terms that fall outside the input image consume a cycle but issue no read.
  function automatic logic term_ok(input logic [5:0] i, input logic [5:0] j,
                                   input logic [3:0] m, input logic [3:0] n);
    return (int'(i) * STRIDE + int'(m) < IN_H) && (int'(j) * STRIDE + int'(n) < IN_W);
  endfunction
endpackage

// File: rtl/conv1_mac.sv
// rtl/conv1_mac.sv - registered multiply-truncate-accumulate, modulo 2^DW.
module conv1_mac
  import conv1_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] acc
);
  logic [DW-1:0] acc_q;
  logic [DW-1:0] prod;

  assign prod = a * b;
  assign acc  = acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc_q <= '0;
    else if (clr) acc_q <= '0;
    else if (en)  acc_q <= acc_q + prod;
  end
endmodule

// File: rtl/conv1_seq.sv
// rtl/conv1_seq.sv - conv1 sequencer: walks outputs and terms, issues reads,
// accumulates returned operand pairs through conv1_mac and streams out pixels.
module conv1_seq
  import conv1_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [7:0]    in_row,
  output logic [7:0]    in_col,
  output logic [1:0]    in_ch,
  output logic [3:0]    k_row,
  output logic [3:0]    k_col,
  output logic [1:0]    k_ch,
  input  logic [DW-1:0] in_data,
  input  logic [DW-1:0] k_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [5:0]    out_row,
  output logic [5:0]    out_col
);
  conv1_seq_state_t state_q;
  logic       busy_q, done_q, rd_q, rd_d1_q, clr_q, valid_q;
  logic [5:0] i_q, j_q;
  logic [1:0] c_q;
  logic [3:0] m_q, n_q;
  logic [7:0] in_row_q, in_col_q;

  logic [1:0] c_d;
  logic [3:0] m_d, n_d;
  logic [5:0] i_d, j_d;
  logic       last_term, last_pos;

  // c/m/n always name the term currently on the address outputs.
  always_comb begin
    last_term = (c_q == 2'(CH - 1)) && (m_q == 4'(K - 1)) && (n_q == 4'(K - 1));
    last_pos  = (i_q == 6'(OUT_H - 1)) && (j_q == 6'(OUT_W - 1));
    c_d = c_q;
    m_d = m_q;
    n_d = n_q + 4'd1;
    if (n_q == 4'(K - 1)) begin
      n_d = '0;
      m_d = m_q + 4'd1;
      if (m_q == 4'(K - 1)) begin
        m_d = '0;
        c_d = c_q + 2'd1;
      end
    end
    i_d = i_q;
    j_d = j_q + 6'd1;
    if (j_q == 6'(OUT_W - 1)) begin
      j_d = '0;
      i_d = i_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_q     <= 1'b0;
      rd_d1_q  <= 1'b0;
      clr_q    <= 1'b0;
      valid_q  <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      c_q      <= '0;
      m_q      <= '0;
      n_q      <= '0;
      in_row_q <= '0;
      in_col_q <= '0;
    end else begin
      clr_q   <= 1'b0;
      rd_d1_q <= rd_q;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_ISSUE;
            busy_q   <= 1'b1;
            clr_q    <= 1'b1;
            i_q      <= '0;
            j_q      <= '0;
            c_q      <= '0;
            m_q      <= '0;
            n_q      <= '0;
            rd_q     <= term_ok(6'd0, 6'd0, 4'd0, 4'd0);
            in_row_q <= '0;
            in_col_q <= '0;
          end
        end
        S_ISSUE: begin
          if (last_term) begin
            state_q <= S_FLUSH;
            rd_q    <= 1'b0;
          end else begin
            c_q      <= c_d;
            m_q      <= m_d;
            n_q      <= n_d;
            rd_q     <= term_ok(i_q, j_q, m_d, n_d);
            in_row_q <= in_addr(i_q, m_d);
            in_col_q <= in_addr(j_q, n_d);
          end
        end
        S_FLUSH: begin
          state_q <= S_OUT;
          valid_q <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            if (last_pos) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q  <= S_ISSUE;
              clr_q    <= 1'b1;
              i_q      <= i_d;
              j_q      <= j_d;
              c_q      <= '0;
              m_q      <= '0;
              n_q      <= '0;
              rd_q     <= term_ok(i_d, j_d, 4'd0, 4'd0);
              in_row_q <= in_addr(i_d, 4'd0);
              in_col_q <= in_addr(j_d, 4'd0);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  conv1_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_q),
    .en    (rd_d1_q),
    .a     (in_data),
    .b     (k_data),
    .acc   (out_data)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_q;
  assign in_row    = in_row_q;
  assign in_col    = in_col_q;
  assign in_ch     = c_q;
  assign k_row     = m_q;
  assign k_col     = n_q;
  assign k_ch      = c_q;
  assign out_valid = valid_q;
  assign out_row   = i_q;
  assign out_col   = j_q;
endmodule

// File: tb/tb_conv1_seq.sv
// tb/tb_conv1_seq.sv - scoreboard bench for conv1_seq against a loop-level
// convolution model fed by address-derived synthetic buffer contents.
module tb_conv1_seq;
  import conv1_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, out_ready;
  logic        busy, done, rd_en, out_valid;
  logic [7:0]  in_row, in_col;
  logic [1:0]  in_ch, k_ch;
  logic [3:0]  k_row, k_col;
  logic [15:0] in_data, k_data, out_data;
  logic [5:0]  out_row, out_col;

  conv1_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .in_row(in_row), .in_col(in_col), .in_ch(in_ch),
    .k_row(k_row), .k_col(k_col), .k_ch(k_ch), .in_data(in_data), .k_data(k_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] data; int row; int col; } exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_err = 0;
  int mode = 0, run_id = -1;
  logic [31:0] seed_in = 0, seed_k = 0;
  int hs_cnt = 0, rd_cnt = 0, done_cnt = 0, stall_left = 0;
  bit bp_en = 0, seen_first = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] f_in(input int md, input int r, input int c, input int ch);
    logic [31:0] h;
    case (md)
      0: return 16'd1;
      1: return 16'd2;
      2: return 16'h0100;
      default: begin
        h = 32'(r) * 32'd131 + 32'(c) * 32'd17 + 32'(ch) * 32'd4099 + seed_in;
        h = h * 32'd40503;
        return h[23:8];
      end
    endcase
  endfunction

  function automatic logic [15:0] f_k(input int md, input int m, input int n, input int ch);
    logic [31:0] h;
    case (md)
      0: return 16'd1;
      1: return 16'd100;
      2: return 16'h0100;
      default: begin
        h = 32'(m) * 32'd29 + 32'(n) * 32'd7 + 32'(ch) * 32'd977 + seed_k;
        h = h * 32'd48271;
        return h[27:12];
      end
    endcase
  endfunction

  // Plain convolution sum for one output pixel, wrapped to 16 bits.
  function automatic logic [15:0] ref_pix(input int i, input int j);
    logic [15:0] s;
    logic [31:0] p;
    s = 16'd0;
    for (int c = 0; c < 3; c++)
      for (int m = 0; m < 11; m++)
        for (int n = 0; n < 11; n++)
          if (i * 4 + m < 227 && j * 4 + n < 227) begin
            p = {16'd0, f_in(mode, i * 4 + m, j * 4 + n, c)} * {16'd0, f_k(mode, m, n, c)};
            s = s + p[15:0];
          end
    return s;
  endfunction

  // Buffer model: operands appear for the whole cycle after the read strobe.
  initial begin : buffers
    bit pend = 0;
    int pr = 0, pc = 0, pch = 0, pm = 0, pn = 0, pkc = 0;
    in_data = 16'd0;
    k_data  = 16'd0;
    forever begin
      @(negedge clk);
      if (pend) begin
        in_data = f_in(mode, pr, pc, pch);
        k_data  = f_k(mode, pm, pn, pkc);
      end else begin
        in_data = 16'($urandom);
        k_data  = 16'($urandom);
      end
      pend = rd_en; pr = int'(in_row); pc = int'(in_col); pch = int'(in_ch);
      pm = int'(k_row); pn = int'(k_col); pkc = int'(k_ch);
    end
  end

  initial begin : ready_drv
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (bp_en && hs_cnt == 3 && out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;
    end
  end

  initial begin : monitor
    bit prev_v = 0, prev_stall = 0;
    logic [15:0] s_data = 0;
    logic [5:0] s_row = 0, s_col = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hs_cnt = 0; rd_cnt = 0; prev_v = 0; prev_stall = 0;
        continue;
      end
      if (done) done_cnt++;
      if (rd_en) begin
        rd_cnt++;
        if (run_id == 0 && hs_cnt == 57) begin
          if (!seen_first) begin
            seen_first = 1;
            check("first_in_row_1_2", in_row, 4);
            check("first_in_col_1_2", in_col, 8);
            check("first_in_ch_1_2", in_ch, 0);
            check("first_k_rc_1_2", {k_row, k_col}, 0);
          end
        end
      end
      if (out_valid && !prev_v) begin
        check("reads_per_output", rd_cnt, 363);
        rd_cnt = 0;
        if (run_id == 0 && hs_cnt == 57) begin
          check("last_in_row_1_2", in_row, 14);
          check("last_in_col_1_2", in_col, 18);
          check("last_ch_1_2", {in_ch, k_ch}, 4'b1010);
          check("last_k_rc_1_2", {k_row, k_col}, 8'hAA);
        end
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, s_data);
        check("stall_pos", {out_row, out_col}, {s_row, s_col});
        check("stall_rd_en", rd_en, 0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb_underflow: output (%0d,%0d) with nothing expected", out_row, out_col);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_row", out_row, e.row);
          check("out_col", out_col, e.col);
        end
        hs_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_v = out_valid;
      s_data = out_data; s_row = out_row; s_col = out_col;
    end
  end

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_pos", {out_row, out_col}, 0);
    check("rst_in_addr", {in_row, in_col, in_ch}, 0);
    check("rst_k_addr", {k_row, k_col, k_ch}, 0);
  endtask

  task automatic push_expected(input int count);
    exp_t e;
    for (int idx = 0; idx < count; idx++) begin
      e.row = idx / 55; e.col = idx % 55;
      e.data = ref_pix(e.row, e.col);
      sb.push_back(e);
    end
  endtask

  task automatic do_start();
    int k;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    check("start_busy", busy, 1);
    check("start_rd_en", rd_en, 1);
    k = 1;
    while (!out_valid && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("first_out_latency", k, 365);
  endtask

  task automatic wait_hs(input int n, input int budget);
    int k = 0;
    while (hs_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("handshakes_reached", hs_cnt, n);
  endtask

  task automatic abort_pass();
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    check("sb_drained", sb.size(), 0);
    check("no_done_mid_pass", done_cnt, 0);
    sb.delete();
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  initial begin : main
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #2 rst_n = 1'b1;

    // Hash data, random backpressure, a 50-cycle stall at (0,3), stray start.
    run_id = 0; mode = 3; seed_in = $urandom; seed_k = $urandom;
    bp_en = 1; stall_left = 50;
    push_expected(60);
    do_start();
    wait_hs(5, 5000);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_hs(60, 40000);
    check("stall_consumed", stall_left, 0);
    check("addr_check_seen", seen_first, 1);
    repeat (20) @(posedge clk);
    abort_pass();
    bp_en = 0;

    run_id = 1; mode = 0;
    push_expected(4);
    do_start();
    wait_hs(4, 3000);
    abort_pass();

    run_id = 2; mode = 1;
    push_expected(3);
    do_start();
    wait_hs(3, 3000);
    abort_pass();

    run_id = 3; mode = 2;
    push_expected(3);
    do_start();
    wait_hs(3, 3000);
    abort_pass();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
